// File: rtl/reg_file_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Optional REG_FILE_WCONFLICT_EN adds a sticky same-address write-conflict flag.
module reg_file_mp #(
   parameter int DEPTH  = 32,
   parameter int WIDTH  = 32,
   parameter int NUM_RD = 3,
   parameter int NUM_WR = 2,
   parameter int BYPASS = 1,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*WIDTH-1:0]  wdata,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*WIDTH-1:0]  rdata,
   output logic [NUM_RD-1:0]        rbusy,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   output logic                     busy_any
`ifdef REG_FILE_WCONFLICT_EN
   ,
   output logic                     wconflict
`endif
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;

   // Later ports are applied last, so the highest-index writer wins; the
   // scoreboard set follows the clears so a new producer supersedes writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy     <= '0;
         busy_any <= 1'b0;
      end else begin
         busy_any <= |busy;
         for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0)) begin
               regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*WIDTH +: WIDTH];
               busy[waddr[k*ADDR_W +: ADDR_W]] <= 1'b0;
            end
         end
         if (sb_set && (sb_addr != '0)) begin
            busy[sb_addr] <= 1'b1;
         end
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic              hit;
      logic [WIDTH-1:0]  fwd;
      rdata = '0;
      rbusy = '0;
      ra    = '0;
      hit   = 1'b0;
      fwd   = '0;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
         ra  = raddr[j*ADDR_W +: ADDR_W];
         hit = 1'b0;
         fwd = '0;
         for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == ra)) begin
               hit = 1'b1;
               fwd = wdata[k*WIDTH +: WIDTH];
            end
         end
         if (ra != '0) begin
            if ((BYPASS != 0) && hit) begin
               rdata[j*WIDTH +: WIDTH] = fwd;
            end else begin
               rdata[j*WIDTH +: WIDTH] = regs[ra];
            end
            // A forwarded write retires the producer unless a new one issues now.
            if ((BYPASS != 0) && hit && !(sb_set && (sb_addr == ra))) begin
               rbusy[j] = 1'b0;
            end else begin
               rbusy[j] = busy[ra];
            end
         end
      end
   end

`ifdef REG_FILE_WCONFLICT_EN
   logic wr_conflict;

   always_comb begin
      wr_conflict = 1'b0;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
         for (int unsigned m = k + 1; m < NUM_WR; m++) begin
            if (we[k] && we[m] &&
                (waddr[k*ADDR_W +: ADDR_W] == waddr[m*ADDR_W +: ADDR_W]) &&
                (waddr[k*ADDR_W +: ADDR_W] != '0)) begin
               wr_conflict = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wconflict <= 1'b0;
      end else if (wr_conflict) begin
         wconflict <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp: one bypassing and one non-bypassing instance
// checked every cycle against an array model, plus directed literal checks.
module tb_reg_file_mp;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 3;
   localparam int NW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NW-1:0]     we;
   logic [NW*AW-1:0]  waddr;
   logic [NW*DW-1:0]  wdata;
   logic [NR*AW-1:0]  raddr;
   logic              sb_set;
   logic [AW-1:0]     sb_addr;
   logic [NR*DW-1:0]  rdata_a, rdata_b;
   logic [NR-1:0]     rbusy_a, rbusy_b;
   logic              busy_any_a, busy_any_b;
   logic              wconflict_a, wconflict_b;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 0;

   // Behavioural model state
   logic [DW-1:0] m_regs [32];
   logic          m_busy [32];
   logic          m_any;
   logic          m_wc;

   always #5 clk = ~clk;

   reg_file_mp #(.DEPTH(32), .WIDTH(32), .NUM_RD(3), .NUM_WR(2), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
      .sb_set(sb_set), .sb_addr(sb_addr), .busy_any(busy_any_a)
`ifdef REG_FILE_WCONFLICT_EN
      , .wconflict(wconflict_a)
`endif
   );

   reg_file_mp #(.DEPTH(32), .WIDTH(32), .NUM_RD(3), .NUM_WR(2), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
      .sb_set(sb_set), .sb_addr(sb_addr), .busy_any(busy_any_b)
`ifdef REG_FILE_WCONFLICT_EN
      , .wconflict(wconflict_b)
`endif
   );

`ifndef REG_FILE_WCONFLICT_EN
   assign wconflict_a = 1'b0;
   assign wconflict_b = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] wa(input int k);
      return waddr[k*AW +: AW];
   endfunction

   function automatic bit written(input logic [AW-1:0] a);
      for (int k = 0; k < NW; k++) if (we[k] && wa(k) == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input int j, input bit byp);
      logic [AW-1:0] a;
      a = raddr[j*AW +: AW];
      if (a == 0) return '0;
      if (byp) begin
         for (int k = NW - 1; k >= 0; k--)
            if (we[k] && wa(k) == a) return wdata[k*DW +: DW];
      end
      return m_regs[a];
   endfunction

   function automatic logic exp_rb(input int j, input bit byp);
      logic [AW-1:0] a;
      a = raddr[j*AW +: AW];
      if (a == 0) return 1'b0;
      if (byp && written(a) && !(sb_set && sb_addr == a)) return 1'b0;
      return m_busy[a];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int a = 0; a < 32; a++) begin
            m_regs[a] = '0;
            m_busy[a] = 1'b0;
         end
         m_any = 1'b0;
         m_wc  = 1'b0;
      end else begin
         m_any = 1'b0;
         for (int a = 1; a < 32; a++) if (m_busy[a]) m_any = 1'b1;
         if (we == 2'b11 && wa(0) == wa(1) && wa(0) != 0) m_wc = 1'b1;
         for (int k = 0; k < NW; k++) begin
            if (we[k] && wa(k) != 0) begin
               m_regs[wa(k)] = wdata[k*DW +: DW];
               m_busy[wa(k)] = 1'b0;
            end
         end
         if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int j = 0; j < NR; j++) begin
            chk($sformatf("rdata_byp[%0d]", j), rdata_a[j*DW +: DW], exp_rd(j, 1'b1));
            chk($sformatf("rdata_nobyp[%0d]", j), rdata_b[j*DW +: DW], exp_rd(j, 1'b0));
            chk($sformatf("rbusy_byp[%0d]", j), {31'b0, rbusy_a[j]}, {31'b0, exp_rb(j, 1'b1)});
            chk($sformatf("rbusy_nobyp[%0d]", j), {31'b0, rbusy_b[j]}, {31'b0, exp_rb(j, 1'b0)});
         end
         chk("busy_any_byp", {31'b0, busy_any_a}, {31'b0, m_any});
         chk("busy_any_nobyp", {31'b0, busy_any_b}, {31'b0, m_any});
`ifdef REG_FILE_WCONFLICT_EN
         chk("wconflict_byp", {31'b0, wconflict_a}, {31'b0, m_wc});
         chk("wconflict_nobyp", {31'b0, wconflict_b}, {31'b0, m_wc});
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = '0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0; reset = 1'b0;
   endtask

   initial begin
      idle();
      raddr = '0;
      reset = 1'b1;
      tick();
      chk_on = 1;
      tick();
      reset = 1'b0;

      // Post-reset reads
      raddr = {5'd31, 5'd5, 5'd1};
      #1;
      chk("reset_rdata", rdata_a[31:0] | rdata_a[63:32] | rdata_a[95:64], 32'h0);
      chk("reset_rbusy", {29'b0, rbusy_a}, 32'h0);
      chk("reset_busy_any", {31'b0, busy_any_a}, 32'h0);
      tick();

      // Write 3 with same-cycle read
      we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hDEADBEEF}; raddr = {5'd0, 5'd0, 5'd3};
      #1;
      chk("bypass_same_cycle", rdata_a[31:0], 32'hDEADBEEF);
      chk("nobypass_same_cycle", rdata_b[31:0], 32'h0);
      tick();
      idle();
      #1;
      chk("nobypass_next_cycle", rdata_b[31:0], 32'hDEADBEEF);
      tick();

      // Register 0 is hardwired
      we = 2'b01; waddr = '0; wdata = {32'h0, 32'h1234}; raddr = '0; sb_set = 1'b1; sb_addr = '0;
      #1;
      chk("r0_same_cycle", rdata_a[31:0], 32'h0);
      tick();
      idle();
      #1;
      chk("r0_next_cycle", rdata_a[31:0] | rdata_b[31:0], 32'h0);
      tick();
      tick();
      chk("r0_sb_set_ignored", {31'b0, busy_any_a}, 32'h0);

      // Dual write to 7: port 1 wins
      we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
      tick();
      idle();
      raddr = {5'd0, 5'd0, 5'd7};
      #1;
      chk("conflict_winner", rdata_a[31:0], 32'h22);
`ifdef REG_FILE_WCONFLICT_EN
      chk("wconflict_set", {31'b0, wconflict_a}, 32'h1);
`endif
      tick();

      // Scoreboard on 9
      sb_set = 1'b1; sb_addr = 5'd9; raddr = {5'd0, 5'd0, 5'd9};
      tick();
      sb_set = 1'b0;
      #1;
      chk("sb_rbusy_next", {31'b0, rbusy_a[0]}, 32'h1);
      chk("sb_busy_any_lag", {31'b0, busy_any_a}, 32'h0);
      tick();
      chk("sb_busy_any", {31'b0, busy_any_a}, 32'h1);
      we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h55};
      #1;
      chk("wb_rbusy_bypass", {31'b0, rbusy_a[0]}, 32'h0);
      chk("wb_rbusy_nobypass", {31'b0, rbusy_b[0]}, 32'h1);
      tick();
      idle();
      #1;
      chk("wb_cleared", {31'b0, rbusy_b[0]}, 32'h0);
      chk("wb_data", rdata_b[31:0], 32'h55);
      tick();
      chk("busy_any_cleared", {31'b0, busy_any_a}, 32'h0);
      sb_set = 1'b1; sb_addr = 5'd9; we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h66};
      #1;
      chk("set_and_wb_rbusy", {31'b0, rbusy_a[0]}, 32'h0);
      tick();
      idle();
      #1;
      chk("set_wins", {31'b0, rbusy_a[0]}, 32'h1);
      chk("set_wb_data", rdata_a[31:0], 32'h66);
`ifdef REG_FILE_WCONFLICT_EN
      chk("wconflict_sticky", {31'b0, wconflict_a}, 32'h1);
`endif
      tick();

      // Mid-operation reset
      sb_set = 1'b1; sb_addr = 5'd4; we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hA5};
      tick();
      idle();
      raddr = {5'd0, 5'd0, 5'd4};
      #1;
      chk("pre_reset_data", rdata_a[31:0], 32'hA5);
      chk("pre_reset_busy", {31'b0, rbusy_a[0]}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("post_reset_data", rdata_a[31:0], 32'h0);
      chk("post_reset_rbusy", {31'b0, rbusy_a[0]}, 32'h0);
      chk("post_reset_busy_any", {31'b0, busy_any_a}, 32'h0);
      chk("post_reset_wconflict", {31'b0, wconflict_a}, 32'h0);
      tick();

      // Randomised traffic over a narrow address range to provoke collisions
      for (int c = 0; c < 3000; c++) begin
         we = NW'($urandom);
         for (int k = 0; k < NW; k++) begin
            waddr[k*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wdata[k*DW +: DW] = $urandom;
         end
         for (int j = 0; j < NR; j++) begin
            if ($urandom_range(0, 2) == 0) raddr[j*AW +: AW] = waddr[$urandom_range(0, NW-1)*AW +: AW];
            else raddr[j*AW +: AW] = AW'($urandom_range(0, 9));
         end
         sb_set  = ($urandom_range(0, 2) == 0);
         sb_addr = ($urandom_range(0, 3) == 0) ? waddr[AW-1:0] : AW'($urandom_range(0, 9));
         reset   = ($urandom_range(0, 149) == 0);
         tick();
      end
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
